// File: rtl/dcache_ctrl_if.sv
// -----------------------------------------------------------------------------
// dcache_ctrl_if
// Bundles the two buses of the data cache controller:
//   Requester side : Rd, Wr, Addr, DataIn -> DataOut, Done, CacheHit, Stall,
//                    Err, DCacheReq
//   Memory side    : mem_rd, mem_wr, mem_addr, mem_wr_data -> mem_rd_data,
//                    mem_ack
// Modports:
//   slave  - the cache controller itself
//   master - the environment (memory stage requester plus backing memory)
// -----------------------------------------------------------------------------
interface dcache_ctrl_if;
   logic        Rd;
   logic        Wr;
   logic [15:0] Addr;
   logic [15:0] DataIn;
   logic [15:0] DataOut;
   logic        Done;
   logic        CacheHit;
   logic        Stall;
   logic        Err;
   logic        DCacheReq;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wr_data;
   logic [15:0] mem_rd_data;
   logic        mem_ack;

   modport slave (
      input  Rd, Wr, Addr, DataIn, mem_rd_data, mem_ack,
      output DataOut, Done, CacheHit, Stall, Err, DCacheReq,
             mem_rd, mem_wr, mem_addr, mem_wr_data
   );

   modport master (
      output Rd, Wr, Addr, DataIn, mem_rd_data, mem_ack,
      input  DataOut, Done, CacheHit, Stall, Err, DCacheReq,
             mem_rd, mem_wr, mem_addr, mem_wr_data
   );
endinterface

// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-back, write-allocate data cache controller sitting
// between the memory stage and a word-wide backing memory. Lines are four
// 16-bit words; a miss on a dirty victim writes the victim back word by word
// before refilling the line word by word.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-low reset (state, valid and dirty bits only)
//   bus  - dcache_ctrl_if.slave
//            Rd/Wr/Addr/DataIn sampled in IDLE; DataOut valid with Done;
//            Done/CacheHit/Err/DCacheReq are single-cycle pulses;
//            Stall high while a request is in flight and Done is low;
//            mem_rd/mem_wr held with a stable mem_addr until mem_ack.
// -----------------------------------------------------------------------------
module dcache_ctrl #(
   parameter int INDEX_W    = 5,
   parameter int LINE_WORDS = 4
) (
   input  logic         clk,
   input  logic         rst,
   dcache_ctrl_if.slave bus
);

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = 13 - INDEX_W;
   localparam int DEPTH = LINES * LINE_WORDS;

   typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, DONE} stateT;

   stateT              state, stateNxt;
   logic [1:0]         wordCnt, wordCntNxt;
   logic               reqRd, reqWr;
   logic [15:0]        reqAddr, reqData;

   logic [LINES-1:0]   validArr, dirtyArr;
   logic [TAG_W-1:0]   tagArr  [LINES];
   logic [15:0]        dataArr [DEPTH];

   logic [TAG_W-1:0]   reqTag;
   logic [INDEX_W-1:0] reqIdx;
   logic [1:0]         reqWord;
   logic [TAG_W-1:0]   victimTag;
   logic               lineHit, illegal;
   logic [15:0]        reqWordData, xferData;

   // control strobes decoded by the FSM
   logic acceptReq, storeEn, fillWrEn, fillDone, wbDone;

   // output values decoded by the FSM
   logic        doneO, hitO, errO, reqPulse, stallO, memRdO, memWrO;
   logic [15:0] memAddrO, memWrDataO, dataOutO;

   assign reqTag      = reqAddr[15:3+INDEX_W];
   assign reqIdx      = reqAddr[2+INDEX_W:3];
   assign reqWord     = reqAddr[2:1];
   assign victimTag   = tagArr[reqIdx];
   assign lineHit     = validArr[reqIdx] && (victimTag == reqTag);
   assign illegal     = (reqRd && reqWr) || reqAddr[0];
   assign reqWordData = dataArr[{reqIdx, reqWord}];
   assign xferData    = dataArr[{reqIdx, wordCnt}];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         wordCnt  <= '0;
         reqRd    <= 1'b0;
         reqWr    <= 1'b0;
         validArr <= '0;
         dirtyArr <= '0;
      end else begin
         state   <= stateNxt;
         wordCnt <= wordCntNxt;
         if (acceptReq) begin
            reqRd <= bus.Rd;
            reqWr <= bus.Wr;
         end
         // valid is only raised once the last fill word lands, so an
         // abandoned refill never exposes a half-written line
         if (fillDone) begin
            validArr[reqIdx] <= 1'b1;
            dirtyArr[reqIdx] <= 1'b0;
         end else if (wbDone) begin
            dirtyArr[reqIdx] <= 1'b0;
         end else if (storeEn) begin
            dirtyArr[reqIdx] <= 1'b1;
         end
      end
   end

   // Datapath storage carries no reset; validity lives in the control bits.
   always_ff @(posedge clk) begin
      if (acceptReq) begin
         reqAddr <= bus.Addr;
         reqData <= bus.DataIn;
      end
      if (fillDone) begin
         tagArr[reqIdx] <= reqTag;
      end
      if (fillWrEn) begin
         dataArr[{reqIdx, wordCnt}] <= bus.mem_rd_data;
      end else if (storeEn) begin
         dataArr[{reqIdx, reqWord}] <= reqData;
      end
   end

   always_comb begin
      stateNxt   = state;
      wordCntNxt = wordCnt;
      acceptReq  = 1'b0;
      storeEn    = 1'b0;
      fillWrEn   = 1'b0;
      fillDone   = 1'b0;
      wbDone     = 1'b0;
      doneO      = 1'b0;
      hitO       = 1'b0;
      errO       = 1'b0;
      reqPulse   = 1'b0;
      stallO     = 1'b0;
      memRdO     = 1'b0;
      memWrO     = 1'b0;
      memAddrO   = '0;
      memWrDataO = '0;
      dataOutO   = '0;

      case (state)
         IDLE: begin
            if (bus.Rd || bus.Wr) begin
               acceptReq = 1'b1;
               stateNxt  = LOOKUP;
            end
         end

         LOOKUP: begin
            stallO     = 1'b1;
            wordCntNxt = '0;
            if (illegal) begin
               errO     = 1'b1;
               stateNxt = IDLE;
            end else begin
               reqPulse = 1'b1;
               if (lineHit) begin
                  doneO    = 1'b1;
                  hitO     = 1'b1;
                  stallO   = 1'b0;
                  storeEn  = reqWr;
                  if (reqRd) begin
                     dataOutO = reqWordData;
                  end
                  stateNxt = IDLE;
               end else if (validArr[reqIdx] && dirtyArr[reqIdx]) begin
                  stateNxt = WB;
               end else begin
                  stateNxt = FILL;
               end
            end
         end

         WB: begin
            stallO     = 1'b1;
            memWrO     = 1'b1;
            memAddrO   = {victimTag, reqIdx, wordCnt, 1'b0};
            memWrDataO = xferData;
            if (bus.mem_ack) begin
               wordCntNxt = wordCnt + 2'd1;
               // counter wraps to 0 here, ready for the refill
               if (wordCnt == 2'd3) begin
                  wbDone   = 1'b1;
                  stateNxt = FILL;
               end
            end
         end

         FILL: begin
            stallO   = 1'b1;
            memRdO   = 1'b1;
            memAddrO = {reqTag, reqIdx, wordCnt, 1'b0};
            if (bus.mem_ack) begin
               fillWrEn   = 1'b1;
               wordCntNxt = wordCnt + 2'd1;
               if (wordCnt == 2'd3) begin
                  fillDone = 1'b1;
                  stateNxt = DONE;
               end
            end
         end

         DONE: begin
            doneO   = 1'b1;
            storeEn = reqWr;
            if (reqRd) begin
               dataOutO = reqWordData;
            end
            stateNxt = IDLE;
         end

         default: begin
            stateNxt = IDLE;
         end
      endcase
   end

   assign bus.Done        = doneO;
   assign bus.CacheHit    = hitO;
   assign bus.Err         = errO;
   assign bus.DCacheReq   = reqPulse;
   assign bus.Stall       = stallO;
   assign bus.DataOut     = dataOutO;
   assign bus.mem_rd      = memRdO;
   assign bus.mem_wr      = memWrO;
   assign bus.mem_addr    = memAddrO;
   assign bus.mem_wr_data = memWrDataO;

endmodule

// File: tb/tb_dcache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_ctrl
// Drives directed and random load/store requests into dcache_ctrl, models the
// backing memory with a programmable ack latency, and predicts every response
// from a line-level cache model (valid/dirty/tag/data per index).
// -----------------------------------------------------------------------------
module tb_dcache_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   dcache_ctrl_if bus();

   dcache_ctrl #(.INDEX_W(5), .LINE_WORDS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      bit          isWr;
      logic [15:0] a;
      logic [15:0] d;
   } xferT;

   xferT logQ[$];
   xferT expQ[$];

   logic [15:0] mem [32768];

   // reference cache model
   bit          mValid [32];
   bit          mDirty [32];
   logic [7:0]  mTag   [32];
   logic [15:0] mData  [128];

   // memory responder controls / observations
   int          ackLat  = 0;
   bit          ackTie  = 1'b0;
   bit          stabErr = 1'b0;
   bit          bothErr = 1'b0;
   int          waitCnt = 0;
   logic [15:0] heldAddr = '0;

   logic [15:0] lastOut;
   int          lastCyc;

   // backing memory: looks at strobes mid-cycle, answers for the next edge
   initial begin
      bus.mem_ack     = 1'b0;
      bus.mem_rd_data = '0;
      forever begin
         @(negedge clk);
         if (rst && (bus.mem_rd || bus.mem_wr)) begin
            if (bus.mem_rd && bus.mem_wr) bothErr = 1'b1;
            if (waitCnt > 0 && bus.mem_addr !== heldAddr) stabErr = 1'b1;
            heldAddr = bus.mem_addr;
            if (ackTie || waitCnt >= ackLat) begin
               bus.mem_ack = 1'b1;
               if (bus.mem_rd) begin
                  bus.mem_rd_data = mem[bus.mem_addr[15:1]];
                  logQ.push_back('{1'b0, bus.mem_addr, mem[bus.mem_addr[15:1]]});
               end else begin
                  mem[bus.mem_addr[15:1]] = bus.mem_wr_data;
                  logQ.push_back('{1'b1, bus.mem_addr, bus.mem_wr_data});
               end
               waitCnt = 0;
            end else begin
               bus.mem_ack = 1'b0;
               waitCnt++;
            end
         end else begin
            bus.mem_ack     = ackTie;
            bus.mem_rd_data = 16'($urandom);
            waitCnt         = 0;
         end
      end
   end

   task automatic modelReset();
      for (int i = 0; i < 32; i++) begin
         mValid[i] = 1'b0;
         mDirty[i] = 1'b0;
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkEq(tag, {25'd0, bus.Done, bus.CacheHit, bus.Err, bus.DCacheReq,
                    bus.Stall, bus.mem_rd, bus.mem_wr}, 32'd0);
   endtask

   task automatic doReq(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] data, input int lat);
      logic [4:0]  idx;
      logic [7:0]  tag;
      logic [1:0]  w;
      logic [1:0]  kk;
      logic [15:0] a;
      logic [15:0] expOut;
      logic [15:0] gotOut;
      bit          isErr, isHit, gotHit, stallBad, completed;
      int          expCyc, cyc, doneCyc, doneCnt, errCnt, reqCnt;

      idx = addr[7:3];
      tag = addr[15:8];
      w   = addr[2:1];
      expQ.delete();
      logQ.delete();
      stabErr = 1'b0;
      bothErr = 1'b0;
      ackLat  = lat;
      isHit   = 1'b0;
      expOut  = '0;
      expCyc  = 1;
      isErr   = (rd && wr) || addr[0];

      if (!isErr) begin
         isHit = mValid[idx] && (mTag[idx] == tag);
         if (!isHit) begin
            if (mValid[idx] && mDirty[idx]) begin
               for (int k = 0; k < 4; k++) begin
                  kk = 2'(k);
                  expQ.push_back('{1'b1, {mTag[idx], idx, kk, 1'b0}, mData[int'(idx)*4+k]});
               end
            end
            for (int k = 0; k < 4; k++) begin
               kk = 2'(k);
               a  = {tag, idx, kk, 1'b0};
               expQ.push_back('{1'b0, a, mem[a[15:1]]});
               mData[int'(idx)*4+k] = mem[a[15:1]];
            end
            mValid[idx] = 1'b1;
            mDirty[idx] = 1'b0;
            mTag[idx]   = tag;
            expCyc = 2 + expQ.size() * ((ackTie ? 0 : lat) + 1);
         end
         expOut = mData[int'(idx)*4+int'(w)];
         if (wr) begin
            mData[int'(idx)*4+int'(w)] = data;
            mDirty[idx] = 1'b1;
         end
      end

      @(negedge clk);
      bus.Rd     = rd;
      bus.Wr     = wr;
      bus.Addr   = addr;
      bus.DataIn = data;
      @(negedge clk);
      bus.Rd     = 1'b0;
      bus.Wr     = 1'b0;
      bus.Addr   = 16'($urandom);
      bus.DataIn = 16'($urandom);

      cyc = 1; doneCyc = -1; doneCnt = 0; errCnt = 0; reqCnt = 0;
      stallBad = 1'b0; completed = 1'b0; gotHit = 1'b0; gotOut = '0;
      while (cyc <= 200) begin
         if (bus.DCacheReq) reqCnt++;
         if (bus.Err) errCnt++;
         if (bus.Done) begin
            doneCnt++;
            doneCyc = cyc;
            gotHit  = bus.CacheHit;
            gotOut  = bus.DataOut;
         end else if (!bus.Err && bus.Stall !== 1'b1) begin
            stallBad = 1'b1;
         end
         if (bus.Done || bus.Err) begin
            completed = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      checkEq("complete", {31'd0, completed}, 32'd1);

      if (isErr) begin
         checkEq("errPulse", errCnt, 1);
         checkEq("errCyc", cyc, 1);
         checkEq("errDone", doneCnt, 0);
         checkEq("errReq", reqCnt, 0);
         checkEq("errMem", logQ.size(), 0);
      end else begin
         checkEq("doneCyc", doneCyc, expCyc);
         checkEq("hitFlag", {31'd0, gotHit}, {31'd0, isHit});
         if (rd) checkEq("dataOut", {16'd0, gotOut}, {16'd0, expOut});
         checkEq("reqPulse", reqCnt, 1);
         checkEq("stallHeld", {31'd0, stallBad}, 32'd0);
         checkEq("memCount", logQ.size(), expQ.size());
         for (int i = 0; i < expQ.size() && i < logQ.size(); i++) begin
            checkEq("memKind", {31'd0, logQ[i].isWr}, {31'd0, expQ[i].isWr});
            checkEq("memAddr", {16'd0, logQ[i].a}, {16'd0, expQ[i].a});
            checkEq("memData", {16'd0, logQ[i].d}, {16'd0, expQ[i].d});
         end
         checkEq("addrStable", {31'd0, stabErr}, 32'd0);
         checkEq("rdWrExcl", {31'd0, bothErr}, 32'd0);
      end
      lastOut = gotOut;
      lastCyc = doneCyc;

      @(negedge clk);
      checkIdleOutputs("idleAfter");
   endtask

   initial begin
      logic [7:0]  rt;
      logic [4:0]  ri;
      logic [1:0]  rw;
      logic        odd;
      int          kind;
      bit          rrd, rwr;

      bus.Rd     = 1'b0;
      bus.Wr     = 1'b0;
      bus.Addr   = '0;
      bus.DataIn = '0;
      for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
      mem[8]  = 16'h00A0;
      mem[9]  = 16'h00A1;
      mem[10] = 16'h00A2;
      mem[11] = 16'h00A3;
      modelReset();

      #1;
      checkIdleOutputs("resetOut");
      checkEq("resetData", {16'd0, bus.DataOut}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // cold load miss, then hit in the same line
      doReq(1'b1, 1'b0, 16'h0010, 16'h0000, 0);
      checkEq("coldData", {16'd0, lastOut}, 32'h00A0);
      doReq(1'b1, 1'b0, 16'h0014, 16'h0000, 0);
      checkEq("hitData", {16'd0, lastOut}, 32'h00A2);
      checkEq("hitLatency", lastCyc, 1);

      // store hit, then conflict miss forcing write-back
      doReq(1'b0, 1'b1, 16'h0012, 16'hBEEF, 0);
      doReq(1'b1, 1'b0, 16'h0110, 16'h0000, 0);
      checkEq("wbBeef", {16'd0, (logQ.size() > 1) ? logQ[1].d : 16'h0000}, 32'h0000BEEF);
      checkEq("memBeef", {16'd0, mem[9]}, 32'h0000BEEF);

      // illegal requests
      doReq(1'b1, 1'b0, 16'h0003, 16'h0000, 0);
      doReq(1'b1, 1'b1, 16'h0020, 16'h1234, 0);

      // slow memory, clean miss
      doReq(1'b1, 1'b0, 16'h0200, 16'h0000, 3);
      checkEq("slowCyc", lastCyc, 18);

      // reset in the middle of a refill
      ackLat = 1;
      logQ.delete();
      @(negedge clk);
      bus.Rd   = 1'b1;
      bus.Addr = 16'h0300;
      @(negedge clk);
      bus.Rd   = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (logQ.size() >= 2) break;
         @(negedge clk);
      end
      checkEq("rstAcks", logQ.size(), 2);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checkEq("rstMemRd", {31'd0, bus.mem_rd}, 32'd0);
      checkEq("rstStall", {31'd0, bus.Stall}, 32'd0);
      checkIdleOutputs("rstOut");
      modelReset();
      @(negedge clk);
      rst = 1'b1;
      doReq(1'b1, 1'b0, 16'h0300, 16'h0000, 1);

      // ack tied high
      ackTie = 1'b1;
      @(negedge clk);
      doReq(1'b1, 1'b0, 16'h0428, 16'h0000, 0);
      checkEq("tieFillCyc", lastCyc, 6);
      doReq(1'b0, 1'b1, 16'h042A, 16'h5A5A, 0);
      doReq(1'b1, 1'b0, 16'h0528, 16'h0000, 0);
      checkEq("tieDirtyCyc", lastCyc, 10);
      ackTie = 1'b0;
      @(negedge clk);

      // random traffic over a few conflicting lines
      for (int n = 0; n < 150; n++) begin
         rt   = 8'($urandom_range(0, 3));
         ri   = 5'($urandom_range(8, 11));
         rw   = 2'($urandom_range(0, 3));
         odd  = ($urandom_range(0, 15) == 0);
         kind = $urandom_range(0, 9);
         rrd  = (kind < 6) || (kind == 9);
         rwr  = (kind >= 6);
         doReq(rrd, rwr, {rt, ri, rw, odd}, 16'($urandom), $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
